// File: rtl/periph_input_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : periph_input_ctrl
// Description : Debounced capture of a peripheral value on a switch press.
//               A request switch and value switches are synchronized, the
//               request is debounced by a four-state FSM, and the value is
//               captured once per accepted press into a read-acknowledged
//               holding register.
//               Optional feature macro: PERIPH_OVERRUN_EN enables the sticky
//               overrun flag; when undefined, overrun is tied to 0.
// Revision    : 1.0 - initial release
// ============================================================================
module periph_input_ctrl #(
    parameter int DATA_W          = 5,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              sw_request,
    input  logic [DATA_W-1:0] sw_value,
    input  logic              read_ack,
    output logic              data_valid,
    output logic [DATA_W-1:0] data_out,
    output logic              overrun
);

    // Counter wide enough to hold DEBOUNCE_CYCLES itself, so it never wraps.
    localparam int                 c_CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);

    localparam logic [1:0] c_IDLE     = 2'd0;
    localparam logic [1:0] c_DEB_RISE = 2'd1;
    localparam logic [1:0] c_HELD     = 2'd2;
    localparam logic [1:0] c_DEB_FALL = 2'd3;

    logic              r_req_meta;
    logic              r_req_s;
    logic [DATA_W-1:0] r_val_meta;
    logic [DATA_W-1:0] r_val_s;
    logic [1:0]        r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic              r_data_valid;
    logic [DATA_W-1:0] r_data_out;
    logic              w_capture;

    // Two-flop synchronizers for the raw asynchronous switch inputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_req_meta <= 1'b0;
            r_req_s    <= 1'b0;
            r_val_meta <= '0;
            r_val_s    <= '0;
        end else begin
            r_req_meta <= sw_request;
            r_req_s    <= r_req_meta;
            r_val_meta <= sw_value;
            r_val_s    <= r_val_meta;
        end
    end

    // The press is accepted on the edge that ends a full rising debounce run.
    assign w_capture = (r_state == c_DEB_RISE) && r_req_s && (r_cnt == c_CNT_MAX);

    // Debounce FSM: a level change needs DEBOUNCE_CYCLES more stable cycles.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= c_IDLE;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (r_req_s) begin
                        r_state <= c_DEB_RISE;
                        r_cnt   <= c_CNT_ONE;
                    end
                end
                c_DEB_RISE: begin
                    if (!r_req_s) begin
                        r_state <= c_IDLE;
                        r_cnt   <= '0;
                    end else if (r_cnt < c_CNT_MAX) begin
                        r_cnt <= r_cnt + c_CNT_ONE;
                    end else begin
                        r_state <= c_HELD;
                        r_cnt   <= '0;
                    end
                end
                c_HELD: begin
                    if (!r_req_s) begin
                        r_state <= c_DEB_FALL;
                        r_cnt   <= c_CNT_ONE;
                    end
                end
                c_DEB_FALL: begin
                    if (r_req_s) begin
                        r_state <= c_HELD;
                        r_cnt   <= '0;
                    end else if (r_cnt < c_CNT_MAX) begin
                        r_cnt <= r_cnt + c_CNT_ONE;
                    end else begin
                        r_state <= c_IDLE;
                        r_cnt   <= '0;
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    // Holding register: a capture beats a simultaneous acknowledge.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_data_valid <= 1'b0;
            r_data_out   <= '0;
        end else if (w_capture) begin
            r_data_valid <= 1'b1;
            r_data_out   <= r_val_s;
        end else if (read_ack && r_data_valid) begin
            r_data_valid <= 1'b0;
        end
    end

    assign data_valid = r_data_valid;
    assign data_out   = r_data_out;

`ifdef PERIPH_OVERRUN_EN
    logic r_overrun;

    // Sticky overrun: set when a capture lands on an unconsumed value.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_overrun <= 1'b0;
        end else if (w_capture) begin
            if (r_data_valid && !read_ack) begin
                r_overrun <= 1'b1;
            end
        end else if (read_ack && r_data_valid) begin
            r_overrun <= 1'b0;
        end
    end

    assign overrun = r_overrun;
`else
    assign overrun = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_periph_input_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_periph_input_ctrl
// Description : Self-checking bench for periph_input_ctrl. Directed press,
//               glitch, acknowledge, overrun and reset scenarios followed by
//               randomized switch activity, all compared each cycle against
//               a run-length reference model of the debounced press.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_periph_input_ctrl;

    localparam int c_DW  = 5;
    localparam int c_DEB = 4;

    logic            clock;
    logic            reset;
    logic            sw_request;
    logic [c_DW-1:0] sw_value;
    logic            read_ack;
    logic            data_valid;
    logic [c_DW-1:0] data_out;
    logic            overrun;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    // Reference model: synchronizer as a two-deep delay line, debounce as the
    // length of the current run of samples disagreeing with the accepted level.
    logic [1:0]      m_req_pipe;
    logic [c_DW-1:0] m_val_pipe [2];
    logic            m_level;
    int              m_run;
    logic            m_dv;
    logic [c_DW-1:0] m_dout;
    logic            m_ov;

    periph_input_ctrl #(
        .DATA_W         (c_DW),
        .DEBOUNCE_CYCLES(c_DEB)
    ) u_dut (
        .clock     (clock),
        .reset     (reset),
        .sw_request(sw_request),
        .sw_value  (sw_value),
        .read_ack  (read_ack),
        .data_valid(data_valid),
        .data_out  (data_out),
        .overrun   (overrun)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    function automatic logic ov_expected();
`ifdef PERIPH_OVERRUN_EN
        return m_ov;
`else
        return 1'b0;
`endif
    endfunction

    task automatic model_edge(input logic rq, input logic [c_DW-1:0] v,
                              input logic ack, input logic rs);
        logic cap;
        if (rs) begin
            m_req_pipe = 2'b00;
            m_val_pipe[0] = '0;
            m_val_pipe[1] = '0;
            m_level = 1'b0;
            m_run   = 0;
            m_dv    = 1'b0;
            m_dout  = '0;
            m_ov    = 1'b0;
        end else begin
            cap = 1'b0;
            if (m_req_pipe[1] != m_level) begin
                m_run++;
                if (m_run == c_DEB + 1) begin
                    m_level = m_req_pipe[1];
                    m_run   = 0;
                    cap     = m_level;
                end
            end else begin
                m_run = 0;
            end
            if (cap && m_dv && !ack) m_ov = 1'b1;
            else if (!cap && ack && m_dv) m_ov = 1'b0;
            if (cap) begin
                m_dv   = 1'b1;
                m_dout = m_val_pipe[1];
            end else if (ack && m_dv) begin
                m_dv = 1'b0;
            end
            m_req_pipe    = {m_req_pipe[0], rq};
            m_val_pipe[1] = m_val_pipe[0];
            m_val_pipe[0] = v;
        end
    endtask

    // One clock: drive inputs, advance model on the edge, compare just after it.
    task automatic step(input logic rq, input logic [c_DW-1:0] v,
                        input logic ack, input logic rs);
        sw_request = rq;
        sw_value   = v;
        read_ack   = ack;
        reset      = rs;
        @(posedge clock);
        cyc++;
        model_edge(rq, v, ack, rs);
        #1;
        check("data_valid", 32'(data_valid), 32'(m_dv));
        check("data_out",   32'(data_out),   32'(m_dout));
        check("overrun",    32'(overrun),    32'(ov_expected()));
    endtask

    task automatic hold(input logic rq, input logic [c_DW-1:0] v, input int n);
        for (int i = 0; i < n; i++) step(rq, v, 1'b0, 1'b0);
    endtask

    initial begin
        int          run_len;
        logic        lvl;
        logic [c_DW-1:0] rv;
        m_req_pipe = 2'b00;
        m_val_pipe[0] = '0;
        m_val_pipe[1] = '0;
        m_level = 1'b0;
        m_run = 0;
        m_dv = 1'b0;
        m_dout = '0;
        m_ov = 1'b0;
        sw_request = 1'b0;
        sw_value   = '0;
        read_ack   = 1'b0;
        reset      = 1'b1;

        // Reset, then request from edge 10: capture visible after edge 16.
        for (int e = 1; e <= 20; e++) begin
            step(e >= 10, 5'h15, 1'b0, e <= 2);
            if (e == 2) begin
                check("rst_dv",   32'(data_valid), 32'd0);
                check("rst_dout", 32'(data_out),   32'd0);
                check("rst_ov",   32'(overrun),    32'd0);
            end
            if (e == 15) check("lat_dv_early", 32'(data_valid), 32'd0);
            if (e == 16) begin
                check("lat_dv",   32'(data_valid), 32'd1);
                check("lat_dout", 32'(data_out),   32'h15);
            end
        end

        // Acknowledge clears valid but keeps the data.
        step(1'b1, 5'h15, 1'b1, 1'b0);
        check("ack_dv",   32'(data_valid), 32'd0);
        check("ack_dout", 32'(data_out),   32'h15);
        step(1'b1, 5'h15, 1'b1, 1'b0);
        check("ack_idle_dv", 32'(data_valid), 32'd0);

        // Second press captures the new value.
        hold(1'b0, 5'h0A, 12);
        hold(1'b1, 5'h0A, 12);
        check("p2_dout", 32'(data_out),   32'h0A);
        check("p2_dv",   32'(data_valid), 32'd1);

        // Two unacknowledged presses.
        step(1'b0, 5'h01, 1'b1, 1'b0);
        hold(1'b0, 5'h01, 12);
        hold(1'b1, 5'h01, 12);
        hold(1'b0, 5'h02, 12);
        hold(1'b1, 5'h02, 12);
        check("ovr_dout", 32'(data_out), 32'h02);
`ifdef PERIPH_OVERRUN_EN
        check("ovr_set", 32'(overrun), 32'd1);
`else
        check("ovr_tied", 32'(overrun), 32'd0);
`endif
        step(1'b1, 5'h02, 1'b1, 1'b0);
        check("ovr_clr_dv", 32'(data_valid), 32'd0);
        check("ovr_clr",    32'(overrun),    32'd0);

        // Glitch of three cycles must not capture.
        hold(1'b0, 5'h1F, 12);
        hold(1'b1, 5'h1F, 3);
        hold(1'b0, 5'h1F, 12);
        check("glitch_dv",   32'(data_valid), 32'd0);
        check("glitch_dout", 32'(data_out),   32'h02);

        // Capture on the same edge as an acknowledge of an older value.
        hold(1'b1, 5'h03, 12);
        hold(1'b0, 5'h03, 12);
        for (int i = 0; i < 12; i++) begin
            step(1'b1, 5'h1C, i == c_DEB + 2, 1'b0);
            if (i == c_DEB + 2) begin
                check("coll_dv",   32'(data_valid), 32'd1);
                check("coll_dout", 32'(data_out),   32'h1C);
                check("coll_ov",   32'(overrun),    32'd0);
            end
        end

        // Reset while rising debounce counter is at 2, then a fresh capture.
        hold(1'b0, 5'h07, 12);
        for (int i = 0; i < 5; i++) step(1'b1, 5'h07, 1'b0, i == 4);
        check("mid_rst_dv",   32'(data_valid), 32'd0);
        check("mid_rst_dout", 32'(data_out),   32'd0);
        check("mid_rst_ov",   32'(overrun),    32'd0);
        for (int i = 1; i <= c_DEB + 3; i++) begin
            step(1'b1, 5'h07, 1'b0, 1'b0);
            if (i == c_DEB + 2) check("re_lat_early", 32'(data_valid), 32'd0);
            if (i == c_DEB + 3) begin
                check("re_lat_dv",   32'(data_valid), 32'd1);
                check("re_lat_dout", 32'(data_out),   32'h07);
            end
        end

        // Randomized switch activity with runs of varying length.
        lvl = 1'b0;
        for (int blk = 0; blk < 600; blk++) begin
            lvl     = ~lvl;
            run_len = $urandom_range(1, 10);
            rv      = c_DW'($urandom);
            for (int i = 0; i < run_len; i++) begin
                step(lvl, rv, ($urandom_range(0, 7) == 0),
                     ($urandom_range(0, 299) == 0));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/periph_input_ctrl.md
PERIPH_INPUT_CTRL -- requirements
Module: periph_input_ctrl

Interface
REQ-001 Parameter DATA_W, default 5: width of the peripheral value path.
REQ-002 Parameter DEBOUNCE_CYCLES, default 4, legal range 1..255: consecutive stable synchronized cycles required to accept a level change.
REQ-003 Port clock, input, 1: sole clock; all state updates on its rising edge.
REQ-004 Port reset, input, 1: synchronous, active-high reset.
REQ-005 Port sw_request, input, 1: raw asynchronous peripheral request switch.
REQ-006 Port sw_value, input, DATA_W: raw asynchronous peripheral value switches.
REQ-007 Port read_ack, input, 1: processor has consumed data_out (single-cycle pulse or level).
REQ-008 Port data_valid, output, 1: data_out holds an unconsumed captured value.
REQ-009 Port data_out, output, DATA_W: last captured value, stable while data_valid=1.
REQ-010 Port overrun, output, 1: sticky flag, a capture overwrote an unconsumed value.

Function
REQ-011 sw_request and sw_value SHALL each pass through a two-flop synchronizer; the FSM SHALL see only the second-stage values (req_s, val_s).
REQ-012 The FSM SHALL have four states: IDLE, DEB_RISE, HELD, DEB_FALL.
REQ-013 IDLE: req_s=1 -> DEB_RISE with counter=1; else stay.
REQ-014 DEB_RISE: req_s=0 -> IDLE, counter cleared; counter<DEBOUNCE_CYCLES and req_s=1 -> counter+1; counter=DEBOUNCE_CYCLES and req_s=1 -> HELD, capture.
REQ-015 Capture SHALL load data_out<=val_s and set data_valid=1 on the same edge as the DEB_RISE->HELD transition.
REQ-016 HELD: req_s=0 -> DEB_FALL with counter=1; else stay; no further capture while HELD (one capture per press).
REQ-017 DEB_FALL: req_s=1 -> HELD, counter cleared; counter<DEBOUNCE_CYCLES and req_s=0 -> counter+1; counter=DEBOUNCE_CYCLES and req_s=0 -> IDLE.
REQ-018 Latency: if raw sw_request is first sampled high at edge k and stays high, data_valid SHALL be 1 after edge k+DEBOUNCE_CYCLES+2.
REQ-019 read_ack=1 with data_valid=1 and no capture on that edge SHALL clear data_valid on that edge; data_out SHALL retain its value.
REQ-020 read_ack with data_valid=0 SHALL have no effect.
REQ-021 Capture and read_ack on the same edge: capture wins, data_valid stays 1, data_out takes the new value, overrun unchanged.
REQ-022 The debounce counter SHALL be ceil(log2(DEBOUNCE_CYCLES+1)) bits wide and SHALL never wrap.
REQ-023 Glitches shorter than DEBOUNCE_CYCLES synchronized cycles SHALL never produce a capture or a release.

Reset
REQ-024 On reset=1 at an edge: state=IDLE, counter=0, synchronizer flops=0, data_valid=0, data_out=0, overrun=0.
REQ-025 Reset mid-debounce or mid-HELD SHALL discard the operation; if sw_request is still high after reset deasserts, a fresh capture SHALL follow per REQ-018.
REQ-026 Reset SHALL take priority over read_ack and capture on the same edge.

Configuration
REQ-027 Macro PERIPH_OVERRUN_EN: when defined, overrun SHALL be set on any capture edge where data_valid=1 and read_ack=0, and cleared only by reset or by read_ack with data_valid=1.
REQ-028 Without PERIPH_OVERRUN_EN, overrun SHALL be tied to 0 and no overrun logic synthesized; all other behaviour identical.

Verification
REQ-029 Reset, then sw_value=5'h15, sw_request held high from edge 10 (DEBOUNCE_CYCLES=4) -> data_valid=1, data_out=5'h15 after edge 16; exactly one capture.
REQ-030 sw_request high for 3 edges then low (DEBOUNCE_CYCLES=4) -> data_valid stays 0, FSM returns to IDLE.
REQ-031 After capture, read_ack pulse -> data_valid=0 next edge, data_out unchanged at 5'h15; second press with sw_value=5'h0A -> data_out=5'h0A.
REQ-032 With PERIPH_OVERRUN_EN: two full presses (5'h01 then 5'h02) with no read_ack -> data_out=5'h02, overrun=1; read_ack -> data_valid=0, overrun=0. Without macro: overrun=0 throughout.
REQ-033 Capture edge coinciding with read_ack -> data_valid=1, new data_out, overrun=0; reset asserted while in DEB_RISE with counter=2 -> all outputs 0, state IDLE.
